// File: rtl/logic_pod_pkg.sv
// Shared definitions for the logic-pod capture word format (7 x 17b blocks in a 128b word, 9 pad MSBs).
package logic_pod_pkg;

  localparam int unsigned LP_BLOCK_BITS      = 17;
  localparam int unsigned LP_BLOCKS_PER_WORD = 7;
  localparam int unsigned LP_PAD_BITS        = 9;
  localparam int unsigned LP_WORD_BITS       = 128;
  localparam int unsigned LP_IDX_BITS        = 3;

  typedef logic [LP_WORD_BITS-1:0] lp_word_t;
  typedef logic [LP_IDX_BITS-1:0]  lp_idx_t;

  localparam lp_idx_t LP_LAST_IDX = lp_idx_t'(LP_BLOCKS_PER_WORD - 1);

  typedef struct packed {
    logic        format;
    logic [15:0] data;
  } lp_block_t;

  // Block 0 sits directly under the pad field; later blocks follow toward bit 0.
  function automatic lp_block_t lp_unpack_block(input lp_word_t word, input lp_idx_t idx);
    lp_word_t sh;
    sh = word >> (LP_BLOCK_BITS * (LP_BLOCKS_PER_WORD - 1 - 32'(idx)));
    return lp_block_t'(sh[LP_BLOCK_BITS-1:0]);
  endfunction

  function automatic logic lp_pad_nonzero(input lp_word_t word);
    return |word[LP_WORD_BITS-1 -: LP_PAD_BITS];
  endfunction

endpackage

// File: rtl/logic_pod_serialization_if.sv
// FIFO read-side and block output bundle for the logic-pod serializer.
interface logic_pod_serialization_if;
  import logic_pod_pkg::*;

  logic        fifo_empty;
  logic        fifo_rd;
  lp_word_t    fifo_rdata;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_format;
  logic [15:0] dout_data;
  logic        pad_err;

  modport master (
    input  fifo_empty, fifo_rdata, dout_ready,
    output fifo_rd, dout_valid, dout_format, dout_data, pad_err
  );

  modport slave (
    output fifo_empty, fifo_rdata, dout_ready,
    input  fifo_rd, dout_valid, dout_format, dout_data, pad_err
  );

endinterface

// File: rtl/logic_pod_word_buffer.sv
// Two-entry (cur/nxt) word queue with one outstanding FIFO read tracked as in-flight.
module logic_pod_word_buffer
  import logic_pod_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_issue,
  input  logic     i_pop,
  input  lp_word_t i_ret_word,
  output logic     o_ret_valid,
  output logic     o_cur_valid,
  output lp_word_t o_cur_word,
  output logic     o_can_issue
);

  logic     r_cur_v;
  logic     r_nxt_v;
  logic     r_inflight;
  lp_word_t r_cur;
  lp_word_t r_nxt;

  logic     w_cur_v_n;
  logic     w_nxt_v_n;
  lp_word_t w_cur_n;
  lp_word_t w_nxt_n;
  logic [1:0] w_occ;

  assign w_occ       = 2'(r_cur_v) + 2'(r_nxt_v) + 2'(r_inflight);
  assign o_can_issue = (w_occ < 2'd2);
  assign o_ret_valid = r_inflight;
  assign o_cur_valid = r_cur_v;
  assign o_cur_word  = r_cur;

  // Apply the retire/promote first, then drop the returning word into whichever slot is free.
  always_comb begin
    w_cur_v_n = r_cur_v;
    w_cur_n   = r_cur;
    w_nxt_v_n = r_nxt_v;
    w_nxt_n   = r_nxt;
    if (i_pop) begin
      w_cur_v_n = r_nxt_v;
      w_cur_n   = r_nxt;
      w_nxt_v_n = 1'b0;
    end
    if (r_inflight) begin
      if (!w_cur_v_n) begin
        w_cur_v_n = 1'b1;
        w_cur_n   = i_ret_word;
      end else begin
        w_nxt_v_n = 1'b1;
        w_nxt_n   = i_ret_word;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_v    <= 1'b0;
      r_nxt_v    <= 1'b0;
      r_inflight <= 1'b0;
      r_cur      <= '0;
      r_nxt      <= '0;
    end else begin
      r_cur_v    <= w_cur_v_n;
      r_nxt_v    <= w_nxt_v_n;
      r_inflight <= i_issue;
      r_cur      <= w_cur_n;
      r_nxt      <= w_nxt_n;
    end
  end

endmodule

// File: rtl/logic_pod_serialization.sv
// Read side of the logic-pod capture CDC FIFO: unpacks 128b words into 17b blocks, MSB slot first.
module logic_pod_serialization
  import logic_pod_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  logic_pod_serialization_if.master lp
);

  logic      w_can_issue;
  logic      w_issue;
  logic      w_ret;
  logic      w_cur_valid;
  lp_word_t  w_cur_word;
  logic      w_src_valid;
  lp_word_t  w_src_word;
  logic      w_load;
  logic      w_take;
  logic      w_pop;
  lp_block_t w_blk;

  lp_idx_t     r_idx;
  logic        r_valid;
  logic        r_format;
  logic [15:0] r_data;
  logic        r_pad_err;

  assign w_issue = !rst && !lp.fifo_empty && w_can_issue;

  // A word returning into an empty buffer feeds the output register directly, giving 2-cycle latency.
  assign w_src_valid = w_cur_valid || w_ret;
  assign w_src_word  = w_cur_valid ? w_cur_word : lp.fifo_rdata;
  assign w_load      = !r_valid || lp.dout_ready;
  assign w_take      = w_load && w_src_valid;
  assign w_pop       = w_take && (r_idx == LP_LAST_IDX);
  assign w_blk       = lp_unpack_block(w_src_word, r_idx);

  logic_pod_word_buffer u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_issue     (w_issue),
    .i_pop       (w_pop),
    .i_ret_word  (lp.fifo_rdata),
    .o_ret_valid (w_ret),
    .o_cur_valid (w_cur_valid),
    .o_cur_word  (w_cur_word),
    .o_can_issue (w_can_issue)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_format  <= 1'b0;
      r_data    <= '0;
      r_pad_err <= 1'b0;
    end else begin
      if (w_load) begin
        r_valid <= w_src_valid;
        if (w_take) begin
          r_format <= w_blk.format;
          r_data   <= w_blk.data;
          r_idx    <= w_pop ? '0 : r_idx + lp_idx_t'(1);
        end
      end
      if (w_ret && lp_pad_nonzero(lp.fifo_rdata)) begin
        r_pad_err <= 1'b1;
      end
    end
  end

  assign lp.fifo_rd     = w_issue;
  assign lp.dout_valid  = r_valid;
  assign lp.dout_format = r_format;
  assign lp.dout_data   = r_data;
  assign lp.pad_err     = r_pad_err;

endmodule

// File: tb/tb_logic_pod_serialization.sv
// Scoreboard bench for logic_pod_serialization: FIFO model feeds words, monitor checks every accepted block.
module tb_logic_pod_serialization;
  import logic_pod_pkg::*;

  logic clk;
  logic rst;

  logic_pod_serialization_if lp();

  logic_pod_serialization dut (
    .clk (clk),
    .rst (rst),
    .lp  (lp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam lp_word_t GARBAGE = {9'h1FF, 119'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A};

  logic [16:0] sbq[$];
  lp_word_t    fq[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          beats    = 0;
  int          rd_cnt   = 0;
  bit          rand_ready = 1'b0;
  bit          prev_stall = 1'b0;
  logic [16:0] prev_val;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic push_word(input logic [8:0] pad, input logic fx, input logic [15:0] base);
    lp_word_t    w;
    logic [16:0] b;
    w = '0;
    w[127:119] = pad;
    for (int k = 0; k < 7; k++) begin
      b = {fx ^ k[0], base + 16'(k)};
      w[118 - 17*k -: 17] = b;
      sbq.push_back(b);
    end
    fq.push_back(w);
  endtask

  task automatic wait_drain(input string name, input int bound);
    int t;
    t = 0;
    while ((sbq.size() != 0 || lp.dout_valid) && t < bound) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(sbq.size()), 32'd0);
  endtask

  // FIFO model: one-cycle read latency, garbage on the data bus when no read was made.
  always @(posedge clk) begin
    if (lp.fifo_rd) begin
      check("rd_not_empty", 32'(lp.fifo_empty), 32'd0);
      rd_cnt++;
      if (fq.size() > 0) lp.fifo_rdata <= fq.pop_front();
      else lp.fifo_rdata <= GARBAGE;
    end else begin
      lp.fifo_rdata <= GARBAGE;
    end
    #1;
    lp.fifo_empty = (fq.size() == 0);
    lp.dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(lp.dout_valid), 32'd1);
        check("stall_hold", 32'({lp.dout_format, lp.dout_data}), 32'(prev_val));
      end
      if (lp.dout_valid && lp.dout_ready) begin
        beats++;
        if (sbq.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got %05h with nothing expected at %0t",
                   {lp.dout_format, lp.dout_data}, $time);
        end else begin
          check("beat", 32'({lp.dout_format, lp.dout_data}), 32'(sbq.pop_front()));
        end
      end
      prev_stall = lp.dout_valid && !lp.dout_ready;
      prev_val   = {lp.dout_format, lp.dout_data};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int r0;
    int t;
    int lat;
    int run;
    int b0;

    rst = 1'b1;
    lp.fifo_empty = 1'b1;
    lp.dout_ready = 1'b1;
    lp.fifo_rdata = '0;

    // Test 1: word queued during reset must not be popped until release
    push_word(9'h000, 1'b0, 16'hA000);
    repeat (3) @(negedge clk);
    check("rst_fifo_empty", 32'(lp.fifo_empty), 32'd0);
    check("rst_fifo_rd", 32'(lp.fifo_rd), 32'd0);
    check("rst_valid", 32'(lp.dout_valid), 32'd0);
    check("rst_format", 32'(lp.dout_format), 32'd0);
    check("rst_data", 32'(lp.dout_data), 32'd0);
    check("rst_pad", 32'(lp.pad_err), 32'd0);
    r0 = rd_cnt;
    rst = 1'b0;
    wait_drain("t1_drain", 100);
    repeat (2) @(negedge clk);
    check("t1_idle_valid", 32'(lp.dout_valid), 32'd0);
    check("t1_rd_count", 32'(rd_cnt - r0), 32'd1);

    // Test 2: three words back-to-back, latency and gapless run
    r0 = rd_cnt;
    push_word(9'h000, 1'b0, 16'hB000);
    push_word(9'h000, 1'b1, 16'hC000);
    push_word(9'h000, 1'b0, 16'hD000);
    t = 0;
    while (!lp.fifo_rd && t < 50) begin
      @(negedge clk);
      t++;
    end
    lat = 0;
    while (!lp.dout_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("t2_latency", 32'(lat), 32'd2);
    run = 0;
    while (lp.dout_valid && run < 40) begin
      run++;
      @(negedge clk);
    end
    check("t2_run_len", 32'(run), 32'd21);
    wait_drain("t2_drain", 100);
    check("t2_rd_count", 32'(rd_cnt - r0), 32'd3);

    // Test 4: FIFO empty gap between words
    r0 = rd_cnt;
    push_word(9'h000, 1'b0, 16'hE000);
    wait_drain("t4_drain0", 100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_gap_valid", 32'(lp.dout_valid), 32'd0);
    end
    push_word(9'h000, 1'b1, 16'hF000);
    wait_drain("t4_drain1", 100);
    check("t4_rd_count", 32'(rd_cnt - r0), 32'd2);

    // Test 3: 100 words under random backpressure
    rand_ready = 1'b1;
    for (int w = 0; w < 100; w++) begin
      push_word(9'h000, w[0], 16'h1000 + 16'(w * 16));
    end
    wait_drain("t3_drain", 6000);
    rand_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Test 5: nonzero pad bits flag pad_err with the first block, sticky afterwards
    check("t5_pad_before", 32'(lp.pad_err), 32'd0);
    push_word(9'h001, 1'b0, 16'h5000);
    t = 0;
    while (!lp.dout_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("t5_pad_first_beat", 32'(lp.pad_err), 32'd1);
    wait_drain("t5_drain0", 100);
    push_word(9'h000, 1'b1, 16'h6000);
    wait_drain("t5_drain1", 100);
    check("t5_pad_sticky", 32'(lp.pad_err), 32'd1);

    // Test 6: reset mid-word with a read in flight
    push_word(9'h000, 1'b0, 16'h7000);
    push_word(9'h000, 1'b1, 16'h7100);
    push_word(9'h000, 1'b0, 16'h7200);
    b0 = beats;
    t = 0;
    while (!((beats - b0) >= 3 && lp.fifo_rd) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("t6_rd_seen", 32'(lp.fifo_rd), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    fq.delete();
    sbq.delete();
    #1;
    check("t6_rst_valid", 32'(lp.dout_valid), 32'd0);
    check("t6_rst_format", 32'(lp.dout_format), 32'd0);
    check("t6_rst_data", 32'(lp.dout_data), 32'd0);
    check("t6_rst_pad", 32'(lp.pad_err), 32'd0);
    check("t6_rst_rd", 32'(lp.fifo_rd), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r0 = rd_cnt;
    push_word(9'h000, 1'b1, 16'h7300);
    wait_drain("t6_drain", 100);
    repeat (2) @(negedge clk);
    check("t6_idle_valid", 32'(lp.dout_valid), 32'd0);
    check("t6_rd_count", 32'(rd_cnt - r0), 32'd1);
    check("t6_pad_after", 32'(lp.pad_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
